// File: rtl/tetris_stats_bcd.sv
// tetris_stats_bcd: score / lines / level bookkeeping between the game logic
// and the renderer. One "lines cleared" event per locked piece updates three
// 6-digit packed BCD counters and the binary level used for gravity speed.
// Optional build macro: TETRIS_STATS_SOFT_DROP_EN adds soft_drop_i, and each
// soft-drop pulse in IDLE adds one point to the score.
module tetris_stats_bcd #(
   parameter int LINES_PER_LEVEL = 10,
   parameter int MAX_LEVEL       = 20,
   parameter int LEVEL_W         = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               lines_valid_i,
   input  logic [2:0]         lines_cleared_i,
`ifdef TETRIS_STATS_SOFT_DROP_EN
   input  logic               soft_drop_i,
`endif
   output logic               busy_o,
   output logic               level_up_o,
   output logic [LEVEL_W-1:0] level_o,
   output logic [23:0]        gd_score_o,
   output logic [23:0]        gd_lines_o,
   output logic [23:0]        gd_level_o
);

   localparam int CNT_W = LEVEL_W + 1;
   // Wide enough for the lines-in-level counter in the worst case
   // (LINES_PER_LEVEL=1 with a level-up on every event until MAX_LEVEL).
   localparam int LL_W  = 9;

   typedef enum logic [2:0] {
      IDLE,
      ADD_LINES,
      ADD_SCORE,
      LEVEL,
      SOFT
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         n_q, n_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LL_W-1:0]    ll_q, ll_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [23:0]        score_q, score_d;
   logic [23:0]        lines_q, lines_d;
   logic [23:0]        glevel_q, glevel_d;
   logic               level_up_q, level_up_d;

   // Whole-word 6-digit BCD add with decimal carry; overflow saturates to 999999.
   function automatic logic [23:0] bcd_add_sat(input logic [23:0] a, input logic [23:0] b);
      logic [23:0] r;
      logic        c;
      logic [4:0]  s;
      r = '0;
      c = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
         if (s > 5'd9) begin
            s = s + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      if (c) begin
         r = 24'h999999;
      end
      return r;
   endfunction

   // Points awarded per multiplier step, in BCD.
   function automatic logic [23:0] base_bcd(input logic [2:0] n);
      logic [23:0] r;
      case (n)
         3'd1:    r = 24'h000040;
         3'd2:    r = 24'h000100;
         3'd3:    r = 24'h000300;
         3'd4:    r = 24'h001200;
         default: r = 24'h000000;
      endcase
      return r;
   endfunction

   // Next-state logic for the FSM and all bookkeeping registers; clear_i overrides.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      ll_d       = ll_q;
      level_d    = level_q;
      score_d    = score_q;
      lines_d    = lines_q;
      glevel_d   = glevel_q;
      level_up_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (lines_valid_i) begin
               n_d     = (lines_cleared_i > 3'd4) ? 3'd4 : lines_cleared_i;
               cnt_d   = CNT_W'(level_q) + CNT_W'(1);
               state_d = ADD_LINES;
            end
`ifdef TETRIS_STATS_SOFT_DROP_EN
            else if (soft_drop_i) begin
               state_d = SOFT;
            end
`endif
         end
         ADD_LINES: begin
            lines_d = bcd_add_sat(lines_q, {21'b0, n_q});
            ll_d    = ll_q + LL_W'(n_q);
            state_d = (n_q == 3'd0) ? IDLE : ADD_SCORE;
         end
         ADD_SCORE: begin
            // Multiplier was latched from the level before this event's level-up.
            score_d = bcd_add_sat(score_q, base_bcd(n_q));
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = LEVEL;
            end
         end
         LEVEL: begin
            if ((ll_q >= LL_W'(LINES_PER_LEVEL)) && (level_q < LEVEL_W'(MAX_LEVEL))) begin
               ll_d       = ll_q - LL_W'(LINES_PER_LEVEL);
               level_d    = level_q + LEVEL_W'(1);
               glevel_d   = bcd_add_sat(glevel_q, 24'h000001);
               level_up_d = 1'b1;
            end else if (ll_q > LL_W'(LINES_PER_LEVEL)) begin
               // Only reachable at MAX_LEVEL: keep the counter from growing.
               ll_d = LL_W'(LINES_PER_LEVEL);
            end
            state_d = IDLE;
         end
         SOFT: begin
            score_d = bcd_add_sat(score_q, 24'h000001);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (clear_i) begin
         state_d    = IDLE;
         n_d        = '0;
         cnt_d      = '0;
         ll_d       = '0;
         level_d    = '0;
         score_d    = '0;
         lines_d    = '0;
         glevel_d   = '0;
         level_up_d = 1'b0;
      end
   end

   // State and bookkeeping registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         cnt_q      <= '0;
         ll_q       <= '0;
         level_q    <= '0;
         score_q    <= '0;
         lines_q    <= '0;
         glevel_q   <= '0;
         level_up_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         ll_q       <= ll_d;
         level_q    <= level_d;
         score_q    <= score_d;
         lines_q    <= lines_d;
         glevel_q   <= glevel_d;
         level_up_q <= level_up_d;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign level_up_o = level_up_q;
   assign level_o    = level_q;
   assign gd_score_o = score_q;
   assign gd_lines_o = lines_q;
   assign gd_level_o = glevel_q;

endmodule

// File: tb/tb_tetris_stats_bcd.sv
// Directed bench for tetris_stats_bcd with a reference model feeding a
// scoreboard queue; each accepted event is compared when busy_o falls.
module tb_tetris_stats_bcd;

   localparam int LPL  = 10;
   localparam int MAXL = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_i;
   logic        lines_valid_i;
   logic [2:0]  lines_cleared_i;
   logic        soft_drop_i;
   logic        busy_o;
   logic        level_up_o;
   logic [4:0]  level_o;
   logic [23:0] gd_score_o;
   logic [23:0] gd_lines_o;
   logic [23:0] gd_level_o;

   int checks = 0;
   int errors = 0;

   // reference model state (plain decimal)
   int m_score, m_lines, m_level, m_ll;

   typedef struct {
      logic [23:0] score;
      logic [23:0] lines;
      logic [23:0] glevel;
      int          level;
      int          busy;
      int          lu;
   } exp_t;

   exp_t sb[$];

   tetris_stats_bcd #(
      .LINES_PER_LEVEL(LPL),
      .MAX_LEVEL(MAXL),
      .LEVEL_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clear_i(clear_i),
      .lines_valid_i(lines_valid_i),
      .lines_cleared_i(lines_cleared_i),
`ifdef TETRIS_STATS_SOFT_DROP_EN
      .soft_drop_i(soft_drop_i),
`endif
      .busy_o(busy_o),
      .level_up_o(level_up_o),
      .level_o(level_o),
      .gd_score_o(gd_score_o),
      .gd_lines_o(gd_lines_o),
      .gd_level_o(gd_level_o)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int          t;
      r = '0;
      t = v;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int sat(input int v);
      return (v > 999999) ? 999999 : v;
   endfunction

   function automatic int base_pts(input int n);
      case (n)
         1:       return 40;
         2:       return 100;
         3:       return 300;
         4:       return 1200;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_score = 0;
      m_lines = 0;
      m_level = 0;
      m_ll    = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_score"}, {8'h0, gd_score_o}, 32'h0);
      chk({tag, "_lines"}, {8'h0, gd_lines_o}, 32'h0);
      chk({tag, "_glevel"}, {8'h0, gd_level_o}, 32'h0);
      chk({tag, "_level"}, {27'h0, level_o}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
      chk({tag, "_levelup"}, {31'h0, level_up_o}, 32'h0);
   endtask

   // Drive one event (optionally with an extra strobe while busy), then
   // pop the expected record and compare once busy_o falls.
   task automatic run_event(input int n, input bit inject);
      exp_t e;
      exp_t g;
      int   nn, bc, lu, guard;
      nn     = (n > 4) ? 4 : n;
      e.busy = (nn == 0) ? 1 : m_level + 3;
      e.lu   = 0;
      if (nn > 0) begin
         m_lines = sat(m_lines + nn);
         m_ll    = m_ll + nn;
         m_score = sat(m_score + base_pts(nn) * (m_level + 1));
         if (m_ll >= LPL && m_level < MAXL) begin
            m_ll = m_ll - LPL;
            m_level++;
            e.lu = 1;
         end else if (m_ll > LPL) begin
            m_ll = LPL;
         end
      end
      e.score  = to_bcd(m_score);
      e.lines  = to_bcd(m_lines);
      e.glevel = to_bcd(m_level);
      e.level  = m_level;
      sb.push_back(e);

      @(negedge clk);
      lines_valid_i   = 1'b1;
      lines_cleared_i = 3'(n);
      @(negedge clk);
      lines_valid_i   = 1'b0;
      bc = 0;
      lu = 0;
      guard = 0;
      while (busy_o && guard < 200) begin
         bc++;
         lu += int'(level_up_o);
         lines_valid_i   = inject && (bc == 1);
         lines_cleared_i = 3'd3;
         @(negedge clk);
         guard++;
      end
      lines_valid_i = 1'b0;
      lu += int'(level_up_o);
      @(negedge clk);
      lu += int'(level_up_o);

      g = sb.pop_front();
      chk("ev_busy_cycles", bc, g.busy);
      chk("ev_levelup_pulses", lu, g.lu);
      chk("ev_score", {8'h0, gd_score_o}, {8'h0, g.score});
      chk("ev_lines", {8'h0, gd_lines_o}, {8'h0, g.lines});
      chk("ev_glevel", {8'h0, gd_level_o}, {8'h0, g.glevel});
      chk("ev_level", {27'h0, level_o}, g.level);
   endtask

   initial begin
      rst             = 1'b1;
      clear_i         = 1'b0;
      lines_valid_i   = 1'b0;
      lines_cleared_i = 3'd0;
      soft_drop_i     = 1'b0;
      model_clear();

      // reset held for two cycles
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_zero("reset");

      // single tetris at level 0
      run_event(4, 1'b0);
      chk("tetris_score", {8'h0, gd_score_o}, 32'h001200);
      chk("tetris_lines", {8'h0, gd_lines_o}, 32'h000004);

      // clear while idle
      @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      model_clear();
      chk_zero("clear_idle");

      // ten singles reach level 1
      for (int i = 0; i < 10; i++) run_event(1, 1'b0);
      chk("ten_glevel", {8'h0, gd_level_o}, 32'h000001);
      chk("ten_score", {8'h0, gd_score_o}, 32'h000400);
      run_event(1, 1'b0);
      chk("lvl1_single_score", {8'h0, gd_score_o}, 32'h000480);

      // a strobe while busy is dropped
      run_event(2, 1'b1);
      chk("drop_strobe_lines", {8'h0, gd_lines_o}, 32'h000013);

      // n=0 event: one busy cycle, nothing changes
      run_event(0, 1'b0);

      // clear during the second ADD_SCORE cycle (level 1 -> two score cycles)
      @(negedge clk);
      lines_valid_i   = 1'b1;
      lines_cleared_i = 3'd1;
      @(negedge clk);
      lines_valid_i = 1'b0;
      chk("mid_busy_addlines", {31'h0, busy_o}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      chk("mid_busy_addscore2", {31'h0, busy_o}, 32'h1);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      model_clear();
      chk_zero("clear_mid");
      run_event(2, 1'b0);
      chk("after_clear_score", {8'h0, gd_score_o}, 32'h000100);

      // climb to MAX_LEVEL and saturate the score (7 is treated as 4)
      begin
         int extra;
         int k;
         extra = 0;
         k = 0;
         while (extra < 3 && k < 150) begin
            run_event((k % 2 == 0) ? 4 : 7, 1'b0);
            if (m_score == 999999) extra++;
            k++;
         end
      end
      chk("sat_score", {8'h0, gd_score_o}, 32'h999999);
      chk("max_level", {27'h0, level_o}, MAXL);
      chk("max_glevel", {8'h0, gd_level_o}, 32'h000020);

`ifdef TETRIS_STATS_SOFT_DROP_EN
      @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      model_clear();
      for (int i = 0; i < 5; i++) begin
         soft_drop_i = 1'b1;
         @(negedge clk);
         soft_drop_i = 1'b0;
         chk("soft_busy", {31'h0, busy_o}, 32'h1);
         @(negedge clk);
         chk("soft_idle", {31'h0, busy_o}, 32'h0);
      end
      chk("soft_score", {8'h0, gd_score_o}, 32'h000005);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
